// File: rtl/unit_fetch_pc_if.sv
// Fetch-stage bus between the PC sequencer, decode, hazard/debug units and instruction memory.
interface unit_fetch_pc_if #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32
);
  logic               i_enable;
  logic               i_stall;
  logic               i_beq;
  logic               i_bne;
  logic               i_is_equal;
  logic [NB_ADDR-1:0] i_branch_address;
  logic               i_jump;
  logic [NB_ADDR-1:0] i_jump_address;
  logic [NB_INST-1:0] i_instr;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_ADDR-1:0] o_ifid_pc_next;
  logic [NB_INST-1:0] o_ifid_instr;
  logic               o_ifid_valid;
  logic               o_redirect;
  logic               o_halted;
  logic [31:0]        o_cycle_count;

  modport master (
    output i_enable, i_stall, i_beq, i_bne, i_is_equal, i_branch_address,
           i_jump, i_jump_address, i_instr,
    input  o_pc, o_ifid_pc_next, o_ifid_instr, o_ifid_valid, o_redirect,
           o_halted, o_cycle_count
  );

  modport slave (
    input  i_enable, i_stall, i_beq, i_bne, i_is_equal, i_branch_address,
           i_jump, i_jump_address, i_instr,
    output o_pc, o_ifid_pc_next, o_ifid_instr, o_ifid_valid, o_redirect,
           o_halted, o_cycle_count
  );
endinterface

// File: rtl/unit_fetch_pc.sv
// Fetch-stage PC sequencer and IF/ID pipeline register with branch/jump redirect,
// stall, debug enable and HALT detection.
module unit_fetch_pc #(
  parameter int                 NB_ADDR  = 32,
  parameter int                 NB_INST  = 32,
  parameter int                 PC_INC   = 1,
  parameter logic [NB_ADDR-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [NB_INST-1:0] HALT_OP  = 32'hFFFF_FFFF
) (
  input logic            i_clock,
  input logic            i_reset,
  unit_fetch_pc_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_r, state_next_s;
  logic [NB_ADDR-1:0] pc_r, pc_next_s, pc_inc_s, target_s;
  logic [NB_ADDR-1:0] ifid_pc_r, ifid_pc_next_s;
  logic [NB_INST-1:0] ifid_instr_r, ifid_instr_next_s;
  logic               ifid_valid_r, ifid_valid_next_s;
  logic [31:0]        count_r, count_next_s;
  logic               taken_s, redirect_s;

  // Redirect decision and next-state selection; one branch per edge-priority level
  always_comb begin
    taken_s           = (bus.i_beq & bus.i_is_equal) | (bus.i_bne & ~bus.i_is_equal);
    redirect_s        = ifid_valid_r & ~bus.i_stall & (taken_s | bus.i_jump);
    target_s          = bus.i_jump ? bus.i_jump_address : bus.i_branch_address;
    pc_inc_s          = pc_r + NB_ADDR'(PC_INC);
    state_next_s      = state_r;
    pc_next_s         = pc_r;
    ifid_pc_next_s    = ifid_pc_r;
    ifid_instr_next_s = ifid_instr_r;
    ifid_valid_next_s = ifid_valid_r;
    count_next_s      = count_r;
    if (!bus.i_enable) begin
      state_next_s = state_r;
    end else if (state_r == ST_HALTED) begin
      ifid_instr_next_s = {NB_INST{1'b0}};
      ifid_valid_next_s = 1'b0;
    end else begin
      count_next_s = count_r + 32'd1;
      if (bus.i_stall) begin
        pc_next_s = pc_r;
      end else if (redirect_s) begin
        // Wrong-path fetch (including a HALT) is squashed by the bubble
        pc_next_s         = target_s;
        ifid_instr_next_s = {NB_INST{1'b0}};
        ifid_valid_next_s = 1'b0;
      end else if (bus.i_instr == HALT_OP) begin
        ifid_pc_next_s    = pc_inc_s;
        ifid_instr_next_s = HALT_OP;
        ifid_valid_next_s = 1'b1;
        state_next_s      = ST_HALTED;
      end else begin
        pc_next_s         = pc_inc_s;
        ifid_pc_next_s    = pc_inc_s;
        ifid_instr_next_s = bus.i_instr;
        ifid_valid_next_s = 1'b1;
      end
    end
  end

  // State register: PC, IF/ID, FSM and run counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_PC;
      ifid_pc_r    <= {NB_ADDR{1'b0}};
      ifid_instr_r <= {NB_INST{1'b0}};
      ifid_valid_r <= 1'b0;
      count_r      <= 32'd0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      ifid_pc_r    <= ifid_pc_next_s;
      ifid_instr_r <= ifid_instr_next_s;
      ifid_valid_r <= ifid_valid_next_s;
      count_r      <= count_next_s;
    end
  end

  assign bus.o_pc           = pc_r;
  assign bus.o_ifid_pc_next = ifid_pc_r;
  assign bus.o_ifid_instr   = ifid_instr_r;
  assign bus.o_ifid_valid   = ifid_valid_r;
  assign bus.o_redirect     = redirect_s;
  assign bus.o_halted       = (state_r == ST_HALTED);
  assign bus.o_cycle_count  = count_r;

endmodule

// File: tb/tb_unit_fetch_pc.sv
// Directed bench for unit_fetch_pc: sequential fetch, branch/jump redirect, stall,
// debug freeze, HALT and PC wrap, with a behavioural imem returning addr+0x100.
module tb_unit_fetch_pc;

  logic        clk;
  logic        rst;
  logic        halt_en;
  logic [31:0] halt_addr;
  int          total;
  int          bad;

  unit_fetch_pc_if #(.NB_ADDR(32), .NB_INST(32)) bus ();

  unit_fetch_pc dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // imem: combinational read, optional HALT planted at one address
  always_comb begin
    if (halt_en && (bus.o_pc == halt_addr)) bus.i_instr = 32'hFFFF_FFFF;
    else bus.i_instr = bus.o_pc + 32'h0000_0100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pcn, input logic [31:0] ins,
                          input logic vld);
    chk({tag, "_pcn"}, bus.o_ifid_pc_next, pcn);
    chk({tag, "_ins"}, bus.o_ifid_instr, ins);
    chk({tag, "_vld"}, {31'd0, bus.o_ifid_valid}, {31'd0, vld});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    halt_en = 1'b0;
    halt_addr = 32'd0;
    bus.i_enable = 1'b1;
    bus.i_stall = 1'b0;
    bus.i_beq = 1'b0;
    bus.i_bne = 1'b0;
    bus.i_is_equal = 1'b0;
    bus.i_branch_address = 32'd0;
    bus.i_jump = 1'b0;
    bus.i_jump_address = 32'd0;
    step();
    step();
    chk("rst_pc", bus.o_pc, 32'd0);
    chk_ifid("rst", 32'd0, 32'd0, 1'b0);
    chk("rst_halted", {31'd0, bus.o_halted}, 32'd0);
    chk("rst_count", bus.o_cycle_count, 32'd0);
    rst = 1'b0;

    step();
    chk("seq1_pc", bus.o_pc, 32'd1);
    chk_ifid("seq1", 32'd1, 32'h100, 1'b1);
    chk("seq1_count", bus.o_cycle_count, 32'd1);
    step();
    chk("seq2_pc", bus.o_pc, 32'd2);
    chk_ifid("seq2", 32'd2, 32'h101, 1'b1);
    step();
    chk("seq3_pc", bus.o_pc, 32'd3);
    step();
    step();
    chk("seq5_pc", bus.o_pc, 32'd5);

    // BEQ taken
    bus.i_beq = 1'b1;
    bus.i_is_equal = 1'b1;
    bus.i_branch_address = 32'h40;
    #1;
    chk("beq_redir", {31'd0, bus.o_redirect}, 32'd1);
    step();
    bus.i_beq = 1'b0;
    #1;
    chk("beq_pc", bus.o_pc, 32'h40);
    chk("beq_bubble", {31'd0, bus.o_ifid_valid}, 32'd0);
    chk("beq_noredir", {31'd0, bus.o_redirect}, 32'd0);
    step();
    chk("beq_tgt_pc", bus.o_pc, 32'h41);
    chk_ifid("beq_tgt", 32'h41, 32'h140, 1'b1);
    chk("beq_count", bus.o_cycle_count, 32'd7);

    // BNE not taken, then taken
    bus.i_bne = 1'b1;
    bus.i_is_equal = 1'b1;
    bus.i_branch_address = 32'h80;
    #1;
    chk("bne_nt_redir", {31'd0, bus.o_redirect}, 32'd0);
    step();
    chk("bne_nt_pc", bus.o_pc, 32'h42);
    chk_ifid("bne_nt", 32'h42, 32'h141, 1'b1);
    bus.i_is_equal = 1'b0;
    #1;
    chk("bne_t_redir", {31'd0, bus.o_redirect}, 32'd1);
    step();
    chk("bne_t_pc", bus.o_pc, 32'h80);
    chk("bne_t_bubble", {31'd0, bus.o_ifid_valid}, 32'd0);
    bus.i_bne = 1'b0;
    step();
    chk("bne_tgt_pc", bus.o_pc, 32'h81);
    chk_ifid("bne_tgt", 32'h81, 32'h180, 1'b1);

    // Stall with a taken BEQ pending
    bus.i_beq = 1'b1;
    bus.i_is_equal = 1'b1;
    bus.i_branch_address = 32'h20;
    bus.i_stall = 1'b1;
    #1;
    chk("stall_redir", {31'd0, bus.o_redirect}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", bus.o_pc, 32'h81);
      chk_ifid("stall", 32'h81, 32'h180, 1'b1);
    end
    chk("stall_count", bus.o_cycle_count, 32'd13);
    bus.i_stall = 1'b0;
    #1;
    chk("unstall_redir", {31'd0, bus.o_redirect}, 32'd1);
    step();
    bus.i_beq = 1'b0;
    chk("unstall_pc", bus.o_pc, 32'h20);
    chk("unstall_bubble", {31'd0, bus.o_ifid_valid}, 32'd0);
    chk("unstall_count", bus.o_cycle_count, 32'd14);
    step();
    chk_ifid("unstall_tgt", 32'h21, 32'h120, 1'b1);

    // Jump beats a simultaneous taken branch
    bus.i_jump = 1'b1;
    bus.i_jump_address = 32'h200;
    bus.i_beq = 1'b1;
    bus.i_branch_address = 32'h300;
    step();
    bus.i_jump = 1'b0;
    bus.i_beq = 1'b0;
    chk("jmp_pc", bus.o_pc, 32'h200);
    step();
    chk("jmp_tgt_pc", bus.o_pc, 32'h201);
    chk_ifid("jmp_tgt", 32'h201, 32'h300, 1'b1);
    chk("jmp_count", bus.o_cycle_count, 32'd17);

    // Debug freeze
    bus.i_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("frz_pc", bus.o_pc, 32'h201);
      chk_ifid("frz", 32'h201, 32'h300, 1'b1);
      chk("frz_count", bus.o_cycle_count, 32'd17);
    end
    bus.i_enable = 1'b1;
    step();
    chk("unfrz_pc", bus.o_pc, 32'h202);
    chk("unfrz_count", bus.o_cycle_count, 32'd18);

    // HALT at pc=7
    halt_en = 1'b1;
    halt_addr = 32'd7;
    bus.i_jump = 1'b1;
    bus.i_jump_address = 32'd7;
    step();
    bus.i_jump = 1'b0;
    chk("h_pc", bus.o_pc, 32'd7);
    step();
    chk("h_pc_hold", bus.o_pc, 32'd7);
    chk_ifid("h_ifid", 32'd8, 32'hFFFF_FFFF, 1'b1);
    chk("h_halted", {31'd0, bus.o_halted}, 32'd1);
    chk("h_count", bus.o_cycle_count, 32'd20);
    step();
    step();
    chk("hd_pc", bus.o_pc, 32'd7);
    chk("hd_vld", {31'd0, bus.o_ifid_valid}, 32'd0);
    chk("hd_ins", bus.o_ifid_instr, 32'd0);
    chk("hd_halted", {31'd0, bus.o_halted}, 32'd1);
    chk("hd_count", bus.o_cycle_count, 32'd20);

    // Reset out of HALTED, then redirect squashes a HALT fetch
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_halted", {31'd0, bus.o_halted}, 32'd0);
    chk("rst2_pc", bus.o_pc, 32'd0);
    chk("rst2_count", bus.o_cycle_count, 32'd0);
    halt_addr = 32'd3;
    step();
    step();
    step();
    chk("rh_pc", bus.o_pc, 32'd3);
    bus.i_jump = 1'b1;
    bus.i_jump_address = 32'h10;
    step();
    bus.i_jump = 1'b0;
    halt_en = 1'b0;
    chk("rh_pc_tgt", bus.o_pc, 32'h10);
    chk("rh_halted", {31'd0, bus.o_halted}, 32'd0);
    chk("rh_vld", {31'd0, bus.o_ifid_valid}, 32'd0);

    // PC wrap at the top of the address space
    step();
    bus.i_jump = 1'b1;
    bus.i_jump_address = 32'hFFFF_FFFF;
    step();
    bus.i_jump = 1'b0;
    chk("wrap_top_pc", bus.o_pc, 32'hFFFF_FFFF);
    step();
    chk("wrap_pc", bus.o_pc, 32'd0);
    chk_ifid("wrap", 32'd0, 32'h0000_00FF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
